// File: rtl/cell_bist_pkg.sv
// Shared types and constants for the cell BIST sequencer.
//   cell_bist_state_t : sequencer state encoding
//   TT_*              : expected truth tables, bit i = expected Y for pattern i
//   TIMER_W           : width of the settle timer
package cell_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } cell_bist_state_t;

  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [1:0] TT_INV   = 2'b01;

  localparam int unsigned TIMER_W = 8;

endpackage

// File: rtl/cell_bist_settle_timer.sv
// Loadable down-counter that times how long stim is held before sampling.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over dec)
//   load_val  : reload value
//   dec       : decrement by one, saturating at zero
//   zero_c    : combinational flag, count is zero
module cell_bist_settle_timer
  import cell_bist_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic               zero_c
);

  logic [TIMER_W-1:0] cnt;

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST sequencer for one library cell: walks every input pattern in ascending
// order, waits SETTLE_CYCLES, samples the cell output against TT and reports
// pass/fail, the number of failing patterns and the first failing pattern.
// Optional build macro: CELL_BIST_STOP_ON_FAIL_EN ends the run at the first
// mismatch.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (honoured in IDLE or DONE only)
//   y_in        : cell output under test
//   stim        : cell input drive (stim[0]=A, stim[1]=B)
//   busy        : run in progress
//   done        : run finished, held until start or rst
//   pass        : no mismatches in the last run (valid with done)
//   fail_count  : number of mismatching patterns
//   first_fail  : index of the first mismatching pattern
module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter int unsigned          N_IN          = 2,
  parameter int unsigned          SETTLE_CYCLES = 3,
  parameter logic [2**N_IN-1:0]   TT            = TT_NAND2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         y_in,
  output logic [N_IN-1:0]              stim,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [$clog2(2**N_IN+1)-1:0] fail_count,
  output logic [N_IN-1:0]              first_fail
);

  localparam int unsigned       FCW         = $clog2(2**N_IN+1);
  localparam logic [N_IN-1:0]   PAT_LAST    = '1;
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);

  cell_bist_state_t state, state_nxt;
  logic [N_IN-1:0]  pattern, pattern_nxt;
  logic [N_IN-1:0]  stim_nxt;
  logic             busy_nxt, done_nxt, pass_nxt;
  logic [FCW-1:0]   fail_count_nxt;
  logic [N_IN-1:0]  first_fail_nxt;
  logic             timer_load, timer_dec, timer_zero_c;
  logic             mismatch_c;

  cell_bist_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (SETTLE_LOAD),
    .dec      (timer_dec),
    .zero_c   (timer_zero_c)
  );

  assign mismatch_c = (y_in != TT[pattern]);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pattern    <= '0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      stim       <= stim_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      fail_count <= fail_count_nxt;
      first_fail <= first_fail_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    pattern_nxt    = pattern;
    stim_nxt       = stim;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    fail_count_nxt = fail_count;
    first_fail_nxt = first_fail;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = APPLY;
          pattern_nxt    = '0;
          stim_nxt       = '0;
          busy_nxt       = 1'b1;
          done_nxt       = 1'b0;
          fail_count_nxt = '0;
          first_fail_nxt = '0;
          timer_load     = 1'b1;
        end
      end

      APPLY: begin
        if (timer_zero_c) begin
          state_nxt = SAMPLE;
        end else begin
          timer_dec = 1'b1;
        end
      end

      SAMPLE: begin
        if (mismatch_c) begin
          fail_count_nxt = fail_count + 1'b1;
          if (fail_count == '0) begin
            first_fail_nxt = pattern;
          end
        end
`ifdef CELL_BIST_STOP_ON_FAIL_EN
        if (mismatch_c || (pattern == PAT_LAST)) begin
`else
        if (pattern == PAT_LAST) begin
`endif
          state_nxt = DONE;
          stim_nxt  = '0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (fail_count_nxt == '0);
        end else begin
          state_nxt   = APPLY;
          pattern_nxt = pattern + 1'b1;
          stim_nxt    = pattern + 1'b1;
          timer_load  = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
